bsg_abs_sat_pipe: RTL and testbench
===================================

Name: bsg_abs_sat_pipe

Overview:
- Registered, multi-lane absolute-value unit with a valid/ready input and a valid/yumi output.
- Each accepted beat carries els_p independent width_p-bit lanes.
- Each lane is either two's-complement signed (magnitude taken) or unsigned (passed through), selected per beat.
- The most-negative input can be saturated, and the unit keeps a sticky saturating count of overflow beats.
- Sits between datapath stages that need a one-cycle, full-throughput, back-pressurable abs.

Parameters:
- width_p, 32, bits per lane (>=2).
- els_p, 1, number of lanes per beat (>=1).
- saturate_p, 1, 1: most-negative input yields 2^(width_p-1)-1; 0: yields 2^(width_p-1) as unsigned.
- cnt_width_p, 8, width of the overflow event counter (>=1).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- v_i  in  1  input beat valid.
- ready_o  out  1  unit can accept a beat this cycle.
- data_i  in  els_p*width_p  lane k at bits [k*width_p +: width_p].
- signed_i  in  1  1: treat lanes as signed; 0: unsigned pass-through.
- v_o  out  1  output beat valid.
- yumi_i  in  1  consumer takes the output beat; legal only when v_o=1.
- data_o  out  els_p*width_p  per-lane result, same packing as data_i.
- neg_o  out  els_p  per-lane flag: input lane was negative (signed beats only).
- ovf_o  out  els_p  per-lane flag: input lane equalled -2^(width_p-1) (signed beats only).
- ovf_cnt_o  out  cnt_width_p  count of accepted beats with any ovf lane set.
- ovf_cnt_clr_i  in  1  synchronous clear of ovf_cnt_o.

Behaviour:
- Reset (sync, active-high; takes effect on the next clk_i edge):
  - v_o=0, data_o=0, neg_o=0, ovf_o=0, ovf_cnt_o=0.
  - A beat held at reset is discarded.
  - Reset overrides accept, yumi and clear in the same cycle.
- Storage is a single output register stage (one entry); no internal FIFO.
- Handshake:
  - ready_o = ~v_o | yumi_i, which is combinational from yumi_i.
  - accept = v_i & ready_o.
  - On an accept edge, the output register loads the new beat and v_o=1.
  - On yumi_i without accept, v_o=0 next cycle.
  - data_o, neg_o and ovf_o hold stable while v_o=1 and yumi_i=0.
  - Simultaneous yumi_i and accept: the old beat leaves and the new beat loads. v_o stays 1, giving a throughput of one beat per cycle.
- Latency: an accepted beat is visible on data_o one cycle after acceptance.
- Per lane x, in width_p-bit arithmetic:
  - signed_i=1 and x[msb]=1 and x != 100..0: data = (~x)+1, neg=1, ovf=0.
  - signed_i=1 and x = 100..0: neg=1, ovf=1; data = 011..1 if saturate_p=1, else 100..0.
  - signed_i=1 and x[msb]=0: data = x, neg=0, ovf=0.
  - signed_i=0: data = x, neg=0, ovf=0.
  - No lane affects any other lane.
- Counter:
  - Increments by 1 on each accept edge whose computed ovf vector is nonzero.
  - Saturates at 2^cnt_width_p-1 (never wraps).
  - ovf_cnt_clr_i=1 forces the counter to 0, even if an increment happens in the same cycle.
  - The counter is independent of yumi_i.
- Data on data_i and signed_i is sampled only on an accept edge. When v_i=0 these inputs are don't-care, and X values on them must not propagate.
- yumi_i asserted with v_o=0 is illegal: the bench asserts on it; the RTL ignores it.

Test Plan:
- Defaults width_p=8, els_p=2, cnt_width_p=2 unless noted.
- Reset, then a single signed beat: data_i={8'h05,8'hFB}, signed_i=1, yumi_i held 1.
  - Next cycle: v_o=1, data_o={8'h05,8'h05}, neg_o=2'b01, ovf_o=0.
  - Following cycle: v_o=0.
- Most-negative lane: data_i={8'h80,8'h80}, signed_i=1, yumi_i held 1.
  - saturate_p=1: data_o={8'h7F,8'h7F}, ovf_o=2'b11, ovf_cnt_o=1.
  - saturate_p=0: data_o={8'h80,8'h80}, ovf_o=2'b11, ovf_cnt_o=1.
- Unsigned mode: data_i={8'hFF,8'h80}, signed_i=0 -> data_o={8'hFF,8'h80}, neg_o=0, ovf_o=0, ovf_cnt_o unchanged.
- Back-pressure:
  - Accept beat A; hold yumi_i=0 for 3 cycles while v_i=1 with beat B.
  - Required: ready_o=0 and data_o=A stable for all 3 cycles.
  - Then assert yumi_i: B is accepted that same cycle and appears next cycle.
  - Then a 10-beat back-to-back stream with yumi_i=1 delivers one beat per cycle, in order.
- Counter: 5 accepted beats containing 8'h80 with signed_i=1.
  - Required: ovf_cnt_o sequence 1,2,3,3,3 (saturated).
  - ovf_cnt_clr_i together with a 6th ovf beat -> ovf_cnt_o=0.
- Reset mid-operation: v_o=1 holding a beat, assert reset_i for 1 cycle.
  - Required: v_o=0, data_o=0, ovf_cnt_o=0 the next cycle.
  - A subsequent beat then behaves normally.

Source files
------------

// File: rtl/bsg_abs_sat_pipe.sv
// rtl/bsg_abs_sat_pipe.sv - registered multi-lane abs with saturation, valid/ready in, valid/yumi out
module bsg_abs_sat_pipe #(
    parameter int width_p     = 32,
    parameter int els_p       = 1,
    parameter int saturate_p  = 1,
    parameter int cnt_width_p = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [els_p*width_p-1:0] data_i,
    input  logic                     signed_i,
    output logic                     v_o,
    input  logic                     yumi_i,
    output logic [els_p*width_p-1:0] data_o,
    output logic [els_p-1:0]         neg_o,
    output logic [els_p-1:0]         ovf_o,
    output logic [cnt_width_p-1:0]   ovf_cnt_o,
    input  logic                     ovf_cnt_clr_i
);

    localparam logic [width_p-1:0]     min_lp     = {1'b1, {(width_p-1){1'b0}}};
    localparam logic [width_p-1:0]     max_lp     = {1'b0, {(width_p-1){1'b1}}};
    localparam logic [width_p-1:0]     one_lp     = {{(width_p-1){1'b0}}, 1'b1};
    localparam logic [width_p-1:0]     sat_val_lp = (saturate_p != 0) ? max_lp : min_lp;
    localparam logic [cnt_width_p-1:0] cnt_max_lp = {cnt_width_p{1'b1}};
    localparam logic [cnt_width_p-1:0] cnt_one_lp = {{(cnt_width_p-1){1'b0}}, 1'b1};

    logic                     v_q, v_d;
    logic [els_p*width_p-1:0] data_q, data_d;
    logic [els_p-1:0]         neg_q, neg_d;
    logic [els_p-1:0]         ovf_q, ovf_d;
    logic [cnt_width_p-1:0]   cnt_q, cnt_d;

    logic [els_p*width_p-1:0] lane_data;
    logic [els_p-1:0]         lane_neg;
    logic [els_p-1:0]         lane_ovf;
    logic                     accept;

    assign ready_o = ~v_q | yumi_i;
    assign accept  = v_i & ready_o;

    // Per-lane magnitude; the most-negative value cannot be negated in width_p bits.
    always_comb begin
        lane_data = '0;
        lane_neg  = '0;
        lane_ovf  = '0;
        for (int k = 0; k < els_p; k++) begin
            if (signed_i && data_i[k*width_p+width_p-1]) begin
                lane_neg[k] = 1'b1;
                if (data_i[k*width_p +: width_p] == min_lp) begin
                    lane_ovf[k]                  = 1'b1;
                    lane_data[k*width_p +: width_p] = sat_val_lp;
                end else begin
                    lane_data[k*width_p +: width_p] = ~data_i[k*width_p +: width_p] + one_lp;
                end
            end else begin
                lane_data[k*width_p +: width_p] = data_i[k*width_p +: width_p];
            end
        end
    end

    // Output stage: load only on accept so idle-cycle inputs never reach the register.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        neg_d  = neg_q;
        ovf_d  = ovf_q;
        if (accept) begin
            v_d    = 1'b1;
            data_d = lane_data;
            neg_d  = lane_neg;
            ovf_d  = lane_ovf;
        end else if (yumi_i) begin
            v_d = 1'b0;
        end
    end

    // Sticky overflow counter: saturates, and clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (|lane_ovf) && (cnt_q != cnt_max_lp)) begin
            cnt_d = cnt_q + cnt_one_lp;
        end
        if (ovf_cnt_clr_i) begin
            cnt_d = '0;
        end
    end

    // State registers with synchronous reset overriding every other update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            neg_q  <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            neg_q  <= neg_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign v_o       = v_q;
    assign data_o    = data_q;
    assign neg_o     = neg_q;
    assign ovf_o     = ovf_q;
    assign ovf_cnt_o = cnt_q;

endmodule

// File: tb/tb_bsg_abs_sat_pipe.sv
// tb/tb_bsg_abs_sat_pipe.sv - self-checking bench for bsg_abs_sat_pipe (saturating and wrapping variants)
module tb_bsg_abs_sat_pipe;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        signed_i;
    logic        yumi_i;
    logic        ovf_cnt_clr_i;

    logic        ready_o_s, v_o_s, ready_o_w, v_o_w;
    logic [15:0] data_o_s, data_o_w;
    logic [1:0]  neg_o_s, neg_o_w, ovf_o_s, ovf_o_w;
    logic [1:0]  cnt_o_s, cnt_o_w;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_v;
    logic [15:0] m_data [2];
    logic [1:0]  m_neg  [2];
    logic [1:0]  m_ovf  [2];
    int          m_cnt  [2];

    bsg_abs_sat_pipe #(.width_p(8), .els_p(2), .saturate_p(1), .cnt_width_p(2)) u_dut_sat (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o_s), .data_i(data_i),
        .signed_i(signed_i), .v_o(v_o_s), .yumi_i(yumi_i), .data_o(data_o_s), .neg_o(neg_o_s),
        .ovf_o(ovf_o_s), .ovf_cnt_o(cnt_o_s), .ovf_cnt_clr_i(ovf_cnt_clr_i)
    );

    bsg_abs_sat_pipe #(.width_p(8), .els_p(2), .saturate_p(0), .cnt_width_p(2)) u_dut_wrap (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o_w), .data_i(data_i),
        .signed_i(signed_i), .v_o(v_o_w), .yumi_i(yumi_i), .data_o(data_o_w), .neg_o(neg_o_w),
        .ovf_o(ovf_o_w), .ovf_cnt_o(cnt_o_w), .ovf_cnt_clr_i(ovf_cnt_clr_i)
    );

    always #5 clk = ~clk;

    // The consumer must never take an empty output register.
    always @(negedge clk) begin
        assert (!(yumi_i && !v_o_s)) else $error("FAIL yumi_without_v: yumi_i=%0b v_o=%0b", yumi_i, v_o_s);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: magnitude by integer arithmetic on each 8-bit lane.
    task automatic ref_beat(input logic [15:0] din, input bit sgn, input bit sat,
                            output logic [15:0] dout, output logic [1:0] n, output logic [1:0] o);
        dout = '0;
        n    = '0;
        o    = '0;
        for (int k = 0; k < 2; k++) begin
            int x;
            int mag;
            x = int'(din[k*8 +: 8]);
            if (sgn && x >= 128) begin
                mag  = 256 - x;
                n[k] = 1'b1;
                if (mag == 128) begin
                    o[k] = 1'b1;
                    mag  = sat ? 127 : 128;
                end
                dout[k*8 +: 8] = mag[7:0];
            end else begin
                dout[k*8 +: 8] = x[7:0];
            end
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [15:0] d, input bit sgn,
                        input bit yen, input bit clr);
        bit          acc;
        logic [15:0] rd;
        logic [1:0]  rn, ro;
        reset_i       = rst;
        v_i           = v;
        data_i        = v ? d : 16'hxxxx;
        signed_i      = v ? sgn : 1'bx;
        yumi_i        = yen & m_v;
        ovf_cnt_clr_i = clr;
        @(negedge clk);
        chk("ready_sat", ready_o_s, !m_v || yumi_i);
        chk("ready_wrap", ready_o_w, !m_v || yumi_i);
        chk("v_sat", v_o_s, m_v);
        chk("v_wrap", v_o_w, m_v);
        chk("cnt_sat", cnt_o_s, m_cnt[0]);
        chk("cnt_wrap", cnt_o_w, m_cnt[1]);
        if (m_v) begin
            chk("data_sat", data_o_s, m_data[0]);
            chk("data_wrap", data_o_w, m_data[1]);
            chk("neg_sat", neg_o_s, m_neg[0]);
            chk("neg_wrap", neg_o_w, m_neg[1]);
            chk("ovf_sat", ovf_o_s, m_ovf[0]);
            chk("ovf_wrap", ovf_o_w, m_ovf[1]);
        end
        acc = v && (!m_v || yumi_i);
        if (rst) begin
            m_v = 0;
            for (int j = 0; j < 2; j++) begin
                m_data[j] = '0; m_neg[j] = '0; m_ovf[j] = '0; m_cnt[j] = 0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (acc) begin
                    ref_beat(d, sgn, (j == 0), rd, rn, ro);
                    m_data[j] = rd; m_neg[j] = rn; m_ovf[j] = ro;
                    if (ro != 0 && m_cnt[j] < 3) m_cnt[j] = m_cnt[j] + 1;
                end
                if (clr) m_cnt[j] = 0;
            end
            if (acc) m_v = 1;
            else if (yumi_i) m_v = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        step(0, 0, 16'h0000, 0, 1, 0);
    endtask

    initial begin
        logic [15:0] d;
        logic [7:0]  nb;
        clk = 0;
        reset_i = 1; v_i = 0; data_i = '0; signed_i = 0; yumi_i = 0; ovf_cnt_clr_i = 0;
        m_v = 0;
        for (int j = 0; j < 2; j++) begin
            m_data[j] = '0; m_neg[j] = '0; m_ovf[j] = '0; m_cnt[j] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", v_o_s, 0);
        chk("rst_data", data_o_s, 16'h0000);
        chk("rst_neg", neg_o_s, 0);
        chk("rst_ovf", ovf_o_s, 0);
        chk("rst_cnt", cnt_o_s, 0);

        step(0, 1, 16'h05FB, 1, 1, 0);
        chk("t1_v", v_o_s, 1);
        chk("t1_data", data_o_s, 16'h0505);
        chk("t1_neg", neg_o_s, 2'b01);
        chk("t1_ovf", ovf_o_s, 2'b00);
        drain();
        chk("t1_v_after", v_o_s, 0);

        step(0, 1, 16'h8080, 1, 1, 0);
        chk("min_data_sat", data_o_s, 16'h7F7F);
        chk("min_data_wrap", data_o_w, 16'h8080);
        chk("min_ovf_sat", ovf_o_s, 2'b11);
        chk("min_ovf_wrap", ovf_o_w, 2'b11);
        chk("min_cnt_sat", cnt_o_s, 1);
        chk("min_cnt_wrap", cnt_o_w, 1);
        drain();

        step(0, 1, 16'hFF80, 0, 1, 0);
        chk("uns_data", data_o_s, 16'hFF80);
        chk("uns_neg", neg_o_s, 0);
        chk("uns_ovf", ovf_o_s, 0);
        chk("uns_cnt", cnt_o_s, 1);
        drain();

        step(0, 1, 16'h03FD, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 16'h10F0, 1, 0, 0);
            chk("bp_ready", ready_o_s, 0);
            chk("bp_data_hold", data_o_s, 16'h0303);
        end
        step(0, 1, 16'h10F0, 1, 1, 0);
        chk("bp_b_v", v_o_s, 1);
        chk("bp_b_data", data_o_s, 16'h1010);
        for (int k = 1; k <= 10; k++) begin
            nb = 8'(256 - k);
            step(0, 1, {nb, nb}, 1, 1, 0);
            chk("stream_v", v_o_s, 1);
            chk("stream_data", data_o_s, {8'(k), 8'(k)});
        end
        drain();
        chk("stream_end_v", v_o_s, 0);

        step(0, 0, 16'h0000, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 16'h8000, 1, 1, 0);
            chk("cnt_seq", cnt_o_s, (i + 1 > 3) ? 3 : i + 1);
        end
        step(0, 1, 16'h8000, 1, 1, 1);
        chk("cnt_clr_wins", cnt_o_s, 0);
        drain();

        step(0, 1, 16'h8080, 1, 0, 0);
        step(1, 1, 16'h0505, 1, 0, 0);
        chk("mid_rst_v", v_o_s, 0);
        chk("mid_rst_data", data_o_s, 16'h0000);
        chk("mid_rst_cnt", cnt_o_s, 0);
        step(0, 1, 16'h05FB, 1, 1, 0);
        chk("post_rst_v", v_o_s, 1);
        chk("post_rst_data", data_o_s, 16'h0505);
        drain();

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(0, 4))
                    0:       d[k*8 +: 8] = 8'h80;
                    1:       d[k*8 +: 8] = 8'h7F;
                    2:       d[k*8 +: 8] = 8'hFF;
                    default: d[k*8 +: 8] = 8'($urandom);
                endcase
            end
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), d,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
